fca1_feed_cu: RTL

Input-side feeder control unit for the fully-connected stage. It owns the read port of the input-feature buffer that the previous layer filled, and streams `IFM_DEPTH` words one at a time into the FC control unit. For each word it raises a one-cycle `start_to_next` pulse and presents the word on a held data register. It is the transmitting end of the `start_from_previous` / `end_to_previous` handshake that the FC control unit receives.

---
 rtl/fca1_feed_cu_pkg.sv | 21 ++
 rtl/fca1_feed_cu_if.sv | 43 ++++
 rtl/fca1_feed_cu_prims.sv | 56 +++++
 rtl/fca1_feed_cu.sv | 114 +++++++++++
 4 files changed

// File: rtl/fca1_feed_cu_pkg.sv
// Shared definitions for the FC-stage input feeder: state encoding and
// the legal range of the input-feature RAM read latency.
package fca1_feed_cu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_GAP   = 2'd2,
    ST_DRAIN = 2'd3
  } feedState_t;

  localparam int RAM_LATENCY_MIN = 1;
  localparam int RAM_LATENCY_MAX = 2;

  // The drain phase is a single cycle, so only latencies of 1 or 2 are
  // handled correctly.
  function automatic bit ramLatencyOk(input int lat);
    return (lat >= RAM_LATENCY_MIN) && (lat <= RAM_LATENCY_MAX);
  endfunction

endpackage

// File: rtl/fca1_feed_cu_if.sv
// Bundle of the feeder's handshake and buffer-read signals. The master side
// is the feeder itself; the slave side is the surrounding datapath (previous
// layer, input-feature RAM and FC control unit).
interface fca1_feed_cu_if #(
  parameter int SIG_DATA_WIDTH   = 32,
  parameter int ADDRESS_SIZE_IFM = 8
);

  logic                        start_from_previous;
  logic                        end_to_previous;
  logic                        end_from_next;
  logic                        ifm_addr_sel;
  logic                        ifm_enable_read;
  logic [ADDRESS_SIZE_IFM-1:0] ifm_address_read_current;
  logic [SIG_DATA_WIDTH-1:0]   ifm_data_in;
  logic [SIG_DATA_WIDTH-1:0]   data_to_next;
  logic                        start_to_next;

  modport master (
    input  start_from_previous,
    input  end_from_next,
    input  ifm_data_in,
    output end_to_previous,
    output ifm_addr_sel,
    output ifm_enable_read,
    output ifm_address_read_current,
    output data_to_next,
    output start_to_next
  );

  modport slave (
    output start_from_previous,
    output end_from_next,
    output ifm_data_in,
    input  end_to_previous,
    input  ifm_addr_sel,
    input  ifm_enable_read,
    input  ifm_address_read_current,
    input  data_to_next,
    input  start_to_next
  );

endinterface

// File: rtl/fca1_feed_cu_prims.sv
// Small reusable building blocks used by the feeder: a fixed-length delay
// line and an enabled data register, both cleared by the async reset.
module delay_2_1 #(
  parameter int delay_cycles = 1,
  parameter int width        = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [width-1:0] d,
  output logic [width-1:0] q
);

  logic [width-1:0] stage_q [delay_cycles];

  // Shift the input through delay_cycles register stages.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < delay_cycles; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q[0] <= d;
      for (int i = 1; i < delay_cycles; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign q = stage_q[delay_cycles-1];

endmodule

module Register #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [DATA_WIDTH-1:0] d,
  output logic [DATA_WIDTH-1:0] q
);

  logic [DATA_WIDTH-1:0] data_q;

  // Capture d when enabled, otherwise hold the stored word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q <= '0;
    end else if (enable) begin
      data_q <= d;
    end
  end

  assign q = data_q;

endmodule

// File: rtl/fca1_feed_cu.sv
// Input-side feeder for the fully-connected stage. Streams IFM_DEPTH words
// from the input-feature buffer into the FC control unit, one word every
// two cycles, each announced by a one-cycle start_to_next pulse.
module fca1_feed_cu
  import fca1_feed_cu_pkg::*;
#(
  parameter int SIG_DATA_WIDTH   = 32,
  parameter int IFM_DEPTH        = 160,
  parameter int RAM_LATENCY      = 1,
  parameter int ADDRESS_SIZE_IFM = $clog2(IFM_DEPTH)
) (
  input logic            clk,
  input logic            reset,
  fca1_feed_cu_if.master bus
);

  localparam logic [ADDRESS_SIZE_IFM-1:0] LAST_ADDR = ADDRESS_SIZE_IFM'(IFM_DEPTH - 1);

  if (!ramLatencyOk(RAM_LATENCY)) begin : gBadLatency
    $error("fca1_feed_cu: RAM_LATENCY must be 1 or 2");
  end

  feedState_t                  state_q, state_d;
  logic [ADDRESS_SIZE_IFM-1:0] addrCnt_q, addrCnt_d;
  logic                        lastWord_q, lastWord_d;
  logic                        readAccept;
  logic                        readValid;
  logic                        endToPrev;
  logic                        addrSel;

  // State, read address and last-word flag; the flag remembers that the
  // read just issued wrapped the counter so GAP can end the frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      addrCnt_q  <= '0;
      lastWord_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      addrCnt_q  <= addrCnt_d;
      lastWord_q <= lastWord_d;
    end
  end

  // Next-state and control decode. end_from_next is only looked at in ISSUE,
  // and a start outside IDLE is ignored. DRAIN lasts exactly one cycle, which
  // covers the extra in-flight read when the RAM latency is 2.
  always_comb begin
    state_d    = state_q;
    addrCnt_d  = addrCnt_q;
    lastWord_d = lastWord_q;
    readAccept = 1'b0;
    endToPrev  = 1'b0;
    addrSel    = 1'b1;
    case (state_q)
      ST_IDLE: begin
        endToPrev = 1'b1;
        addrSel   = 1'b0;
        if (bus.start_from_previous) begin
          lastWord_d = 1'b0;
          state_d    = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (bus.end_from_next) begin
          readAccept = 1'b1;
          lastWord_d = (addrCnt_q == LAST_ADDR);
          addrCnt_d  = (addrCnt_q == LAST_ADDR) ? '0 : addrCnt_q + ADDRESS_SIZE_IFM'(1);
          state_d    = ST_GAP;
        end
      end
      ST_GAP: begin
        if (lastWord_q) begin
          state_d = (RAM_LATENCY > 1) ? ST_DRAIN : ST_IDLE;
        end else begin
          state_d = ST_ISSUE;
        end
      end
      ST_DRAIN: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  delay_2_1 #(
    .delay_cycles (RAM_LATENCY),
    .width        (1)
  ) uReadValid (
    .clk   (clk),
    .reset (reset),
    .d     (readAccept),
    .q     (readValid)
  );

  Register #(
    .DATA_WIDTH (SIG_DATA_WIDTH)
  ) uDataReg (
    .clk    (clk),
    .reset  (reset),
    .enable (readValid),
    .d      (bus.ifm_data_in),
    .q      (bus.data_to_next)
  );

  assign bus.end_to_previous          = endToPrev;
  assign bus.ifm_addr_sel             = addrSel;
  assign bus.ifm_enable_read          = readAccept;
  assign bus.ifm_address_read_current = addrCnt_q;
  assign bus.start_to_next            = readValid;

endmodule
